// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register transmit/receive pair.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shift_state_e;

  localparam int unsigned WIDTH_DEFAULT  = 16;
  localparam int unsigned BYTE_LEN       = 8;
  localparam int unsigned WORD_FRAME_LEN = WIDTH_DEFAULT;
  localparam int unsigned BYTE_FRAME_LEN = BYTE_LEN;

  // Index of the last bit of a frame: the bit counter's load value.
  function automatic int unsigned frame_last(input logic byte_mode, input int unsigned width);
    return (byte_mode ? BYTE_FRAME_LEN : width) - 1;
  endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter with a registered zero flag.
module bit_down_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             decEn,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Zero is computed alongside the count so it is valid from the next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      zero  <= (load_val == '0);
    end else if (decEn) begin
      count <= count - CNT_W'(1);
      zero  <= (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver for MSB-first frames, with a
// valid/ack holding register so the next frame can arrive during readout.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             startEn,
  input  logic             byteMode,
  input  logic             shiftEn,
  input  logic             serialIn,
  input  logic             dataAck,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  shift_state_e     state;
  logic [WIDTH-2:0] shift_q;
  logic             byte_q;
  logic [CNT_W-1:0] load_val;
  logic             cnt_zero;
  logic             capture;
  logic [WIDTH-1:0] word_next;

  // startEn has priority over a coincident strobe.
  always_comb begin
    load_val  = CNT_W'(frame_last(byteMode, WIDTH));
    capture   = (state == SHIFT) && shiftEn && !startEn;
    word_next = {shift_q, serialIn};
    if (byte_q) begin
      word_next = {{(WIDTH-BYTE_LEN){1'b0}}, shift_q[BYTE_LEN-2:0], serialIn};
    end
  end

  bit_down_counter #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (startEn),
    .load_val (load_val),
    .decEn    (capture),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      byte_q    <= 1'b0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (dataAck) begin
        dataValid <= 1'b0;
      end
      if (startEn) begin
        state   <= SHIFT;
        busy    <= 1'b1;
        byte_q  <= byteMode;
        shift_q <= '0;
        if (!dataValid) begin
          overrun <= 1'b0;
        end
      end else if (capture) begin
        shift_q <= word_next[WIDTH-2:0];
        if (cnt_zero) begin
          state <= IDLE;
          busy  <= 1'b0;
          // A coincident ack frees the holding register for this word.
          if (!dataValid || dataAck) begin
            dataOut   <= word_next;
            dataValid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench: directed frames plus random traffic against a frame-level model.
module tb_shift_deserializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        startEn, byteMode, shiftEn, serialIn, dataAck;
  logic [15:0] dataOut;
  logic        dataValid, busy, overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy;
  int          m_len;
  int          m_got;
  logic [15:0] m_word;
  logic [15:0] m_out;
  bit          m_valid;
  bit          m_ovr;

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .startEn   (startEn),
    .byteMode  (byteMode),
    .shiftEn   (shiftEn),
    .serialIn  (serialIn),
    .dataAck   (dataAck),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_len = 0; m_got = 0; m_word = '0;
    m_out = '0; m_valid = 0; m_ovr = 0;
  endtask

  // One clock of the frame-level behaviour, using the inputs seen at the edge.
  task automatic model_step(input bit st, input bit bm, input bit sh, input bit si, input bit ack);
    bit nv;
    nv = m_valid && !ack;
    if (st) begin
      if (!m_valid) m_ovr = 0;
      m_busy = 1;
      m_len  = bm ? 8 : 16;
      m_got  = 0;
      m_word = '0;
    end else if (m_busy && sh) begin
      m_word = (m_word << 1) | 16'(si);
      if (m_len == 8) m_word = m_word & 16'h00FF;
      m_got++;
      if (m_got == m_len) begin
        m_busy = 0;
        if (!m_valid || ack) begin
          m_out = m_word;
          nv    = 1;
        end else begin
          m_ovr = 1;
        end
      end
    end
    m_valid = nv;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dataOut"},   32'(dataOut),   32'(m_out));
    check({tag, ".dataValid"}, 32'(dataValid), 32'(m_valid));
    check({tag, ".busy"},      32'(busy),      32'(m_busy));
    check({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
  endtask

  // Inputs are applied away from the edge; outputs are checked 1 ns after it.
  task automatic cycle(input bit st, input bit bm, input bit sh, input bit si, input bit ack,
                       input string tag);
    startEn = st; byteMode = bm; shiftEn = sh; serialIn = si; dataAck = ack;
    @(posedge clk);
    model_step(st, bm, sh, si, ack);
    #1;
    check_outputs(tag);
    startEn = 0; shiftEn = 0; dataAck = 0; serialIn = 0; byteMode = 0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int len, input bit ack_last, input string tag);
    logic [15:0] v;
    v = w;
    for (int i = len - 1; i >= 0; i--) begin
      cycle(0, 0, 1, v[i], ack_last && (i == 0), tag);
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input bit bm, input bit ack_last, input string tag);
    cycle(1, bm, 0, 0, 0, tag);
    send_bits(w, bm ? 8 : 16, ack_last, tag);
  endtask

  initial begin
    reset_n = 0; startEn = 0; byteMode = 0; shiftEn = 0; serialIn = 0; dataAck = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset_n = 1;

    send_frame(16'hA5C3, 0, 0, "word");
    check("word_value", 32'(dataOut), 32'h0000A5C3);
    check("word_valid", 32'(dataValid), 32'd1);
    check("word_busy", 32'(busy), 32'd0);

    cycle(0, 0, 0, 0, 1, "ack1");
    send_frame(16'h009E, 1, 0, "byte");
    check("byte_value", 32'(dataOut), 32'h0000009E);

    cycle(0, 0, 0, 0, 1, "ack2");
    send_frame(16'h1234, 0, 0, "ovr_a");
    send_frame(16'hFFFF, 0, 0, "ovr_b");
    check("ovr_hold", 32'(dataOut), 32'h00001234);
    check("ovr_flag", 32'(overrun), 32'd1);
    cycle(0, 0, 0, 0, 1, "ovr_ack");
    cycle(1, 0, 0, 0, 0, "ovr_start");
    check("ovr_clear", 32'(overrun), 32'd0);

    send_frame(16'h1111, 0, 0, "coin_a");
    send_frame(16'h2222, 0, 1, "coin_b");
    check("coin_value", 32'(dataOut), 32'h00002222);
    check("coin_valid", 32'(dataValid), 32'd1);
    check("coin_ovr", 32'(overrun), 32'd0);

    cycle(0, 0, 0, 0, 1, "ack3");
    cycle(1, 0, 0, 0, 0, "abort");
    send_bits(16'h001F, 5, 0, "abort_part");
    cycle(1, 0, 1, 1, 0, "abort_prio");
    send_bits(16'h00FF, 16, 0, "abort_frame");
    check("abort_value", 32'(dataOut), 32'h000000FF);

    cycle(1, 0, 0, 0, 0, "rst_mid");
    send_bits(16'h01AB, 9, 0, "rst_bits");
    reset_n = 0;
    #2;
    model_reset();
    check_outputs("rst_async");
    reset_n = 1;
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 1, 0, "idle_strobe");
    check("idle_valid", 32'(dataValid), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(39) == 0), $urandom_range(1), $urandom_range(1),
            $urandom_range(1), ($urandom_range(7) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-in, parallel-out receiver for the MSB-first shift stream produced by the team's 16-bit parallel-load shift register. It samples one bit per `shiftEn` strobe and assembles a 16-bit word, or an 8-bit word in byte mode. Completed words are handed to a holding register with a valid/acknowledge handshake, so a new frame can be received while the consumer is still reading the previous word.

## Interface
- `WIDTH`, 16, full word length in bits.
- `BYTE_LEN`, 8, frame length when `byteMode` = 1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `startEn`  in  1  arms the receiver and clears the bit counter; aborts any frame in progress.
- `byteMode`  in  1  sampled with `startEn`: 1 = 8-bit frame, 0 = WIDTH-bit frame.
- `shiftEn`  in  1  one-cycle sample strobe; `serialIn` is captured when it is high.
- `serialIn`  in  1  serial data, MSB first.
- `dataAck`  in  1  consumer acknowledge; clears `dataValid`.
- `dataOut`  out  WIDTH  received word; byte frames are right-aligned with upper bits 0.
- `dataValid`  out  1  `dataOut` holds an unacknowledged word.
- `busy`  out  1  a frame is in progress.
- `overrun`  out  1  sticky; a completed word was dropped.

## Operation
- FSM states:
  - IDLE: waits for `startEn`.
  - SHIFT: collects bits.
  - Any state → IDLE on reset.
- IDLE → SHIFT on `startEn`. Loads the bit counter with frame length − 1 (15 or 7), latches `byteMode`, and clears the shift register.
- In SHIFT, each `shiftEn`:
  - shift register becomes `{shift[WIDTH-2:0], serialIn}`;
  - counter decrements.
- When the counter reaches 0 and `shiftEn` is high, the frame completes and the state returns to IDLE:
  - If `dataValid` = 0, or `dataAck` = 1 in the same cycle: the assembled word goes to `dataOut` (byte frames as `{8'h00, shift[6:0], serialIn}`) and `dataValid` is set.
  - Otherwise: `dataOut` is unchanged and `overrun` is set.
- `shiftEn` in IDLE is ignored. Extra strobes after a complete frame are not captured.
- `startEn` in SHIFT aborts the frame: partial bits are discarded and the receiver restarts. No `dataValid`, no `overrun`.
- `startEn` and `shiftEn` in the same cycle: `startEn` wins and the bit is not captured.
- `dataAck` with `dataValid` = 0 has no effect.
- `overrun` clears only on reset or on `startEn` issued while `dataValid` = 0.
- `busy` = (state == SHIFT).

## Timing
- Reset values:
  - `dataOut` = 0, `dataValid` = 0, `busy` = 0, `overrun` = 0.
  - State IDLE, counter 0.
- Reset takes effect immediately and asynchronously, including mid-frame. Any partial word is lost.
- `busy` rises in the cycle after `startEn`.
- The first bit can be captured on the `shiftEn` in the cycle after `startEn`.
- `dataValid` and `dataOut` update on the same edge that captures the last bit. They are visible the following cycle.
- Latency from the last `shiftEn` to `dataValid` = 1 clock.
- `dataValid` stays high until the edge on which `dataAck` is sampled high. It is low the next cycle unless a frame completes on that same edge, in which case it stays high with the new word.
- Back-to-back frames: `startEn` may be asserted in the cycle after completion.
- Minimum full-frame time = 1 + WIDTH cycles.

## Structure
- Shared package `shift_pkg`:
  - state enum {IDLE, SHIFT};
  - `WIDTH_DEFAULT` = 16, `BYTE_LEN` = 8;
  - frame-length constants used by both this block and the transmit shift register.
- One sub-module, `bit_down_counter`: loadable down-counter with load value, `decEn`, and a `zero` flag. The top level holds the FSM, shift register, holding register and flags.

## Test plan
- Word frame: reset, `startEn`, then 16 `shiftEn` with `serialIn` bits of 0xA5C3 MSB first → `dataOut` = 0xA5C3, `dataValid` = 1 one cycle after the 16th strobe, `busy` = 0.
- Byte mode: `startEn` with `byteMode` = 1, send 0x9E → `dataOut` = 0x009E after the 8th strobe.
- Overrun: receive 0x1234 without ack, then receive 0xFFFF → `dataOut` stays 0x1234, `overrun` = 1. Then `dataAck`, then `startEn` → `overrun` = 0.
- Ack coincident with completion: hold 0x1111 valid, and assert `dataAck` on the edge capturing the last bit of 0x2222 → `dataOut` = 0x2222, `dataValid` remains 1, `overrun` = 0.
- Abort and priority: after 5 bits, assert `startEn` together with `shiftEn`, then send 0x00FF → `dataOut` = 0x00FF.
- Reset mid-frame: drop `reset_n` after 9 bits → all outputs 0 immediately. `shiftEn` strobes with no `startEn` → no capture.
